// File: rtl/fpseq_pkg.sv
// Shared types and default widths for the fp register-file sequencer.
// Optional performance counters are enabled with FPSEQ_PERF_EN.
package fpseq_pkg;

    localparam int FPSEQ_ADDR_W = 5;
    localparam int FPSEQ_DATA_W = 32;
    localparam int FPSEQ_CNT_W  = 16;

    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_CHECK = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RA,
        RB,
        RC,
        EX,
        WB
    } state_t;

endpackage

// File: rtl/fpseq_perf.sv
// Purpose: saturating response / CHECK-miss counter pair (only built under FPSEQ_PERF_EN).
// Latency: counters update one cycle after the response pulse.
// Backpressure: none; observes the response pulse only.
module fpseq_perf
    import fpseq_pkg::*;
#(
    parameter int CNT_W = FPSEQ_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             resp_valid,
    input  logic             resp_check,
    input  logic             resp_match,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count   <= '0;
            miss_count <= '0;
        end else begin
            if (resp_valid && (op_count != '1))
                op_count <= op_count + CNT_ONE;
            if (resp_valid && resp_check && !resp_match && (miss_count != '1))
                miss_count <= miss_count + CNT_ONE;
        end
    end

endmodule

// File: rtl/fp_rf_sequencer.sv
// Purpose: sequences a single-port register file and an external fp adder (ADD / CHECK commands).
// Latency: write 5 cycles after accept, response pulse and ready 6 cycles after accept.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are ignored. Perf counters under FPSEQ_PERF_EN.
module fp_rf_sequencer
    import fpseq_pkg::*;
#(
    parameter int ADDR_W = FPSEQ_ADDR_W,
    parameter int DATA_W = FPSEQ_DATA_W
`ifdef FPSEQ_PERF_EN
    ,
    parameter int CNT_W  = FPSEQ_CNT_W
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [DATA_W-1:0] fa_a,
    output logic [DATA_W-1:0] fa_b,
    input  logic [DATA_W-1:0] fa_sum,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_match
`ifdef FPSEQ_PERF_EN
    ,
    output logic [CNT_W-1:0]  op_count,
    output logic [CNT_W-1:0]  miss_count
`endif
);

    state_t            state, state_nxt;
    logic              op_q;
    logic [ADDR_W-1:0] src_a_q, src_b_q, dst_q;
    logic [DATA_W-1:0] opa, opb, opc, sum;

    assign fa_a = opa;
    assign fa_b = opb;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Read data lags the address by one cycle, so each operand is captured one state after its read.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rf_addr   = '0;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        case (state)
            IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid) state_nxt = RA;
            end
            RA: begin
                rf_addr   = src_a_q;
                state_nxt = RB;
            end
            RB: begin
                rf_addr   = src_b_q;
                state_nxt = RC;
            end
            RC: begin
                rf_addr   = dst_q;
                state_nxt = EX;
            end
            EX: state_nxt = WB;
            WB: begin
                rf_addr   = dst_q;
                state_nxt = IDLE;
                if ((op_q == OP_ADD) && !reset) begin
                    rf_we    = 1'b1;
                    rf_wdata = sum;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= OP_ADD;
            src_a_q    <= '0;
            src_b_q    <= '0;
            dst_q      <= '0;
            opa        <= '0;
            opb        <= '0;
            opc        <= '0;
            sum        <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_match <= 1'b0;
        end else begin
            resp_valid <= (state == WB);
            if ((state == IDLE) && cmd_valid) begin
                op_q    <= cmd_op;
                src_a_q <= cmd_src_a;
                src_b_q <= cmd_src_b;
                dst_q   <= cmd_dst;
            end
            case (state)
                RB: opa <= rf_rdata;
                RC: opb <= rf_rdata;
                EX: begin
                    opc <= rf_rdata;
                    sum <= fa_sum;
                end
                WB: begin
                    resp_data  <= sum;
                    resp_match <= (op_q == OP_CHECK) && (sum == opc);
                end
                default: ;
            endcase
        end
    end

`ifdef FPSEQ_PERF_EN
    fpseq_perf #(.CNT_W(CNT_W)) u_perf (
        .clk        (clk),
        .reset      (reset),
        .resp_valid (resp_valid),
        .resp_check (op_q),
        .resp_match (resp_match),
        .op_count   (op_count),
        .miss_count (miss_count)
    );
`endif

endmodule
